// File: rtl/multi_rect_renderer.sv
// multi_rect_renderer: draws up to NRECT solid rectangles over a background
// colour with a two-stage pixel pipeline, and optionally bounces each enabled
// rectangle inside the active area once per frame. Lower index wins on overlap.
module multi_rect_renderer #(
  parameter int COORDWID = 10,
  parameter int CHANWID  = 4,
  parameter int NRECT    = 4,
  parameter int VELWID   = 4,
  parameter int HRES     = 640,
  parameter int VRES     = 480,
  parameter int H_OFFSET = 48,
  parameter int V_OFFSET = 33,
  parameter logic [3*CHANWID-1:0] BG_COLOR = 12'h142,
  localparam int IDXW = $clog2(NRECT)
) (
  input  logic                   pix_clk,
  input  logic                   rst_pix_n,
  input  logic [COORDWID-1:0]    sx,
  input  logic [COORDWID-1:0]    sy,
  input  logic                   de,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic                   frame,
  input  logic                   anim_en,
  input  logic                   cfg_we,
  input  logic [IDXW-1:0]        cfg_idx,
  input  logic [COORDWID-1:0]    cfg_x,
  input  logic [COORDWID-1:0]    cfg_y,
  input  logic [COORDWID-1:0]    cfg_w,
  input  logic [COORDWID-1:0]    cfg_h,
  input  logic [VELWID-1:0]      cfg_dx,
  input  logic [VELWID-1:0]      cfg_dy,
  input  logic [3*CHANWID-1:0]   cfg_color,
  output logic                   busy,
  output logic [CHANWID-1:0]     o_r,
  output logic [CHANWID-1:0]     o_g,
  output logic [CHANWID-1:0]     o_b,
  output logic                   o_de,
  output logic                   o_hsync,
  output logic                   o_vsync
);

  localparam int CW1 = COORDWID + 1;
  localparam int NW  = COORDWID + 3;
  localparam int PVW = COORDWID + VELWID;
  localparam int CLW = 3 * CHANWID;

  typedef enum logic {ST_IDLE, ST_UPDATE} state_t;

  // Rectangle register file
  logic [COORDWID-1:0]      rx_q   [NRECT];
  logic [COORDWID-1:0]      ry_q   [NRECT];
  logic [COORDWID-1:0]      rw_q   [NRECT];
  logic [COORDWID-1:0]      rh_q   [NRECT];
  logic signed [VELWID-1:0] rdx_q  [NRECT];
  logic signed [VELWID-1:0] rdy_q  [NRECT];
  logic [CLW-1:0]           rcol_q [NRECT];
  logic [NRECT-1:0]         en;

  // Pixel pipeline
  logic signed [CW1-1:0]    px, py;
  logic [CW1-1:0]           px_u, py_u;
  logic [NRECT-1:0]         hit;
  logic [NRECT-1:0]         hit_p1;
  logic                     vld_p1, hs_p1, vs_p1;
  logic [CLW-1:0]           pix_sel;
  logic [CLW-1:0]           color_p2;
  logic                     vld_p2, hs_p2, vs_p2;

  // Update FSM
  state_t                   state_q, state_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [PVW-1:0]           bx, by;

  // One axis of the bounce step; returns {new_pos, new_vel}. Sums are carried
  // wide enough that neither the step nor the far-edge test can wrap.
  function automatic logic [PVW-1:0] bounce(
    input logic [COORDWID-1:0]    pos,
    input logic signed [VELWID-1:0] vel,
    input logic [COORDWID-1:0]    size,
    input int                     lim
  );
    logic signed [NW-1:0]     n;
    logic signed [NW-1:0]     lim_s;
    logic signed [NW-1:0]     size_s;
    logic [COORDWID-1:0]      pos_n;
    logic signed [VELWID-1:0] vel_n;
    lim_s  = NW'(lim);
    size_s = $signed({3'b000, size});
    n      = $signed({3'b000, pos}) + NW'(vel);
    pos_n  = pos;
    vel_n  = vel;
    if (size_s >= lim_s) begin
      pos_n = '0;
    end else if (vel != 0) begin
      if (n < 0) begin
        pos_n = '0;
        vel_n = -vel;
      end else if (n + size_s > lim_s) begin
        pos_n = COORDWID'(lim_s - size_s);
        vel_n = -vel;
      end else begin
        pos_n = COORDWID'(n);
      end
    end
    return {pos_n, vel_n};
  endfunction

  // A zero width or height disables a rectangle
  always_comb begin
    en = '0;
    for (int i = 0; i < NRECT; i++) begin
      en[i] = (|rw_q[i]) && (|rh_q[i]);
    end
  end

  // Active-area coordinates; the MSB flags a position left of / above the area
  assign px   = {1'b0, sx} - CW1'(H_OFFSET);
  assign py   = {1'b0, sy} - CW1'(V_OFFSET);
  assign px_u = {1'b0, px[COORDWID-1:0]};
  assign py_u = {1'b0, py[COORDWID-1:0]};

  // Per-rectangle containment test against [x,x+w) x [y,y+h)
  always_comb begin
    hit = '0;
    for (int i = 0; i < NRECT; i++) begin
      hit[i] = en[i] && !px[CW1-1] && !py[CW1-1]
            && (px_u >= {1'b0, rx_q[i]})
            && (px_u <  ({1'b0, rx_q[i]} + {1'b0, rw_q[i]}))
            && (py_u >= {1'b0, ry_q[i]})
            && (py_u <  ({1'b0, ry_q[i]} + {1'b0, rh_q[i]}));
    end
  end

  // ---- stage 1: register hit vector and delayed sync/enable ----
  always_ff @(posedge pix_clk or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      hit_p1 <= '0;
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
    end else begin
      hit_p1 <= hit;
      vld_p1 <= de;
      hs_p1  <= hsync;
      vs_p1  <= vsync;
    end
  end

  // Fixed priority: scanning downward lets the lowest hit index win
  always_comb begin
    pix_sel = BG_COLOR;
    for (int i = NRECT - 1; i >= 0; i--) begin
      if (hit_p1[i]) pix_sel = rcol_q[i];
    end
  end

  // ---- stage 2: register colour (blanked outside de) and delayed syncs ----
  always_ff @(posedge pix_clk or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      color_p2 <= '0;
      vld_p2   <= 1'b0;
      hs_p2    <= 1'b0;
      vs_p2    <= 1'b0;
    end else begin
      color_p2 <= vld_p1 ? pix_sel : '0;
      vld_p2   <= vld_p1;
      hs_p2    <= hs_p1;
      vs_p2    <= vs_p1;
    end
  end

  assign o_r     = color_p2[CLW-1 -: CHANWID];
  assign o_g     = color_p2[2*CHANWID-1 -: CHANWID];
  assign o_b     = color_p2[CHANWID-1:0];
  assign o_de    = vld_p2;
  assign o_hsync = hs_p2;
  assign o_vsync = vs_p2;

  // Update FSM state and rectangle index registers
  always_ff @(posedge pix_clk or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: one rectangle per cycle, frame pulses ignored while updating
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (frame && anim_en) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
        end
      end
      ST_UPDATE: begin
        if (idx_q == IDXW'(NRECT - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == ST_UPDATE);
  end

  assign bx = bounce(rx_q[idx_q], rdx_q[idx_q], rw_q[idx_q], HRES);
  assign by = bounce(ry_q[idx_q], rdy_q[idx_q], rh_q[idx_q], VRES);

  // Rectangle registers: a config write beats the animation step on the same index
  always_ff @(posedge pix_clk or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int i = 0; i < NRECT; i++) begin
        rx_q[i]   <= '0;
        ry_q[i]   <= '0;
        rw_q[i]   <= '0;
        rh_q[i]   <= '0;
        rdx_q[i]  <= '0;
        rdy_q[i]  <= '0;
        rcol_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NRECT; i++) begin
        if (cfg_we && (cfg_idx == IDXW'(i))) begin
          rx_q[i]   <= cfg_x;
          ry_q[i]   <= cfg_y;
          rw_q[i]   <= cfg_w;
          rh_q[i]   <= cfg_h;
          rdx_q[i]  <= $signed(cfg_dx);
          rdy_q[i]  <= $signed(cfg_dy);
          rcol_q[i] <= cfg_color;
        end else if (busy && (idx_q == IDXW'(i)) && en[i]) begin
          rx_q[i]  <= bx[PVW-1:VELWID];
          rdx_q[i] <= $signed(bx[VELWID-1:0]);
          ry_q[i]  <= by[PVW-1:VELWID];
          rdy_q[i] <= $signed(by[VELWID-1:0]);
        end
      end
    end
  end

endmodule
